// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM state encoding and timeout defaults.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    RESP
  } apb_state_e;

  localparam int APB_TIMEOUT_DEFAULT = 16;
  localparam int APB_WAIT_CNT_W      = 5;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus signals of the command master.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: turns one command into one SETUP/ACCESS transfer
// and returns a response, with a bounded wait on pready.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_cmd_master_if.master bus
);

  localparam logic [APB_WAIT_CNT_W-1:0] CNT_ONE     = APB_WAIT_CNT_W'(1);
  localparam logic [APB_WAIT_CNT_W-1:0] TIMEOUT_CNT = APB_WAIT_CNT_W'(TIMEOUT);

  apb_state_e                state_q;
  logic [APB_WAIT_CNT_W-1:0] wait_cnt_q;
  logic [APB_WAIT_CNT_W-1:0] wait_cnt_d;
  logic                      cmd_ready_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [ADDR_W-1:0]         paddr_q;
  logic [DATA_W-1:0]         pwdata_q;
  logic                      rsp_valid_q;
  logic                      rsp_err_q;
  logic [DATA_W-1:0]         rsp_rdata_q;

  assign wait_cnt_d = wait_cnt_q + CNT_ONE;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= bus.cmd_write;
            paddr_q     <= bus.cmd_addr;
            pwdata_q    <= bus.cmd_wdata;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= pwrite_q;
            state_q     <= pwrite_q ? RESP : CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            // The cycle that brings the count to TIMEOUT is the last ACCESS cycle.
            if (wait_cnt_d == TIMEOUT_CNT) begin
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        CAPTURE: begin
          // Slave read data is registered on the completion edge, so sample it one cycle later.
          rsp_rdata_q <= bus.prdata;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: register-file slave with programmable wait states and a
// word-level model of its contents; directed scenarios followed by random traffic.
module tb_apb_cmd_master;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] RO_ADDR = 32'h0000_0004;
  localparam logic [31:0] RO_VAL  = 32'h5A5A_5555;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (ifc)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Register slave: word 1 (address 0x4) is read-only, others are plain storage.
  logic [31:0] slv_mem [16] = '{default: 32'h0};
  logic [31:0] prdata_q = 32'h0;
  int          wait_n   = 0;
  logic        stall    = 1'b0;
  int          acc_cnt  = 0;

  assign ifc.pready = !stall && (acc_cnt >= wait_n);
  assign ifc.prdata = prdata_q;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (ifc.psel && ifc.penable && !ifc.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (presetn && ifc.psel && ifc.penable && ifc.pready) begin
      if (ifc.pwrite) begin
        if (ifc.paddr != RO_ADDR) slv_mem[ifc.paddr[5:2]] <= ifc.pwdata;
      end else begin
        prdata_q <= (ifc.paddr == RO_ADDR) ? RO_VAL : slv_mem[ifc.paddr[5:2]];
      end
    end
  end

  // Per-cycle APB ordering monitor.
  int          acc_total  = 0;
  logic        prev_psel  = 1'b0;
  logic        prev_pen   = 1'b0;
  logic        prev_rdy   = 1'b0;
  logic        prev_wr    = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  always @(negedge pclk) begin
    if (presetn && ifc.penable) begin
      acc_total <= acc_total + 1;
      check1("apb_penable_without_psel", ifc.psel, 1'b1);
      check1("apb_access_without_setup", prev_psel, 1'b1);
      check1("apb_access_after_done", prev_pen && prev_rdy, 1'b0);
      check32("apb_paddr_stable", ifc.paddr, prev_addr);
      check32("apb_pwdata_stable", ifc.pwdata, prev_wdata);
      check1("apb_pwrite_stable", ifc.pwrite, prev_wr);
    end
    prev_psel  <= ifc.psel;
    prev_pen   <= ifc.penable;
    prev_rdy   <= ifc.pready;
    prev_wr    <= ifc.pwrite;
    prev_addr  <= ifc.paddr;
    prev_wdata <= ifc.pwdata;
  end

  // Expected slave contents, updated only from the commands the bench issues.
  logic [31:0] exp_mem [16];

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return (addr == RO_ADDR) ? RO_VAL : exp_mem[addr[5:2]];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr != RO_ADDR) exp_mem[addr[5:2]] = data;
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = wr;
    ifc.cmd_addr  = addr;
    ifc.cmd_wdata = wdata;
    while (!ifc.cmd_ready && n < 100) begin
      step();
      n++;
    end
    check1("cmd_accept_bound", n < 100, 1'b1);
    accept_cyc = cyc;
    step();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
    int n = 0;
    while (!ifc.rsp_valid && n < 100) begin
      step();
      n++;
    end
    checki({tag, "_latency"}, cyc - accept_cyc, exp_lat);
    check32({tag, "_rdata"}, ifc.rsp_rdata, exp_rdata);
    check1({tag, "_err"}, ifc.rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      step();
      check1({tag, "_hold_valid"}, ifc.rsp_valid, 1'b1);
      check32({tag, "_hold_rdata"}, ifc.rsp_rdata, exp_rdata);
      check1({tag, "_hold_err"}, ifc.rsp_err, exp_err);
      check1({tag, "_hold_cmd_ready"}, ifc.cmd_ready, 1'b0);
      check1({tag, "_hold_psel"}, ifc.psel, 1'b0);
    end
    ifc.rsp_ready = 1'b1;
    step();
    ifc.rsp_ready = 1'b0;
    check1({tag, "_rsp_done"}, ifc.rsp_valid, 1'b0);
    check1({tag, "_ready_again"}, ifc.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [3:0]  word;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          snap;
    int          hold;

    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 32'h0;
    ifc.cmd_wdata = 32'h0;
    ifc.rsp_ready = 1'b0;

    // Reset state.
    #12;
    check1("rst_psel", ifc.psel, 1'b0);
    check1("rst_penable", ifc.penable, 1'b0);
    check1("rst_pwrite", ifc.pwrite, 1'b0);
    check32("rst_paddr", ifc.paddr, 32'h0);
    check32("rst_pwdata", ifc.pwdata, 32'h0);
    check1("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    check1("rst_rsp_err", ifc.rsp_err, 1'b0);
    check32("rst_rsp_rdata", ifc.rsp_rdata, 32'h0);
    presetn = 1'b1;
    step();
    check1("post_rst_cmd_ready", ifc.cmd_ready, 1'b1);

    // Read of the read-only register.
    issue(1'b0, 32'h4, 32'h0);
    collect("rd_ro", 0, RO_VAL, 1'b0, 4);

    // Write then read back.
    issue(1'b1, 32'h8, 32'hDEAD_BEEF);
    model_write(32'h8, 32'hDEAD_BEEF);
    collect("wr_8", 0, 32'h0, 1'b0, 3);
    issue(1'b0, 32'h8, 32'h0);
    collect("rd_8", 0, model_read(32'h8), 1'b0, 4);

    // Write to the read-only register leaves it unchanged.
    issue(1'b1, 32'h4, 32'h1111_1111);
    model_write(32'h4, 32'h1111_1111);
    collect("wr_ro", 0, 32'h0, 1'b0, 3);
    issue(1'b0, 32'h4, 32'h0);
    collect("rd_ro_again", 0, RO_VAL, 1'b0, 4);

    // Slave never ready: 16 ACCESS cycles, then an error response.
    stall = 1'b1;
    snap  = acc_total;
    issue(1'b0, 32'hC, 32'h0);
    collect("timeout", 0, 32'h0, 1'b1, 2 + TIMEOUT);
    checki("timeout_access_cycles", acc_total - snap, TIMEOUT);
    stall = 1'b0;
    issue(1'b1, 32'hC, 32'h1234_5678);
    model_write(32'hC, 32'h1234_5678);
    collect("after_to_wr", 0, 32'h0, 1'b0, 3);
    issue(1'b0, 32'hC, 32'h0);
    collect("after_to_rd", 0, model_read(32'hC), 1'b0, 4);

    // Response back-pressure with a command already offered.
    issue(1'b1, 32'h10, 32'hCAFE_0001);
    model_write(32'h10, 32'hCAFE_0001);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_write = 1'b0;
    ifc.cmd_addr  = 32'h10;
    ifc.cmd_wdata = 32'h0;
    collect("backpressure", 5, 32'h0, 1'b0, 3);
    issue(1'b0, 32'h10, 32'h0);
    checki("offered_cmd_no_wait", accept_cyc, cyc - 1);
    collect("offered_rd", 0, model_read(32'h10), 1'b0, 4);

    // Reset during ACCESS abandons the transfer.
    stall = 1'b1;
    issue(1'b0, 32'h14, 32'h0);
    step();
    step();
    check1("pre_rst_psel", ifc.psel, 1'b1);
    check1("pre_rst_penable", ifc.penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check1("mid_rst_psel", ifc.psel, 1'b0);
    check1("mid_rst_penable", ifc.penable, 1'b0);
    check1("mid_rst_rsp_valid", ifc.rsp_valid, 1'b0);
    step();
    step();
    presetn = 1'b1;
    stall   = 1'b0;
    step();
    check1("rel_rst_cmd_ready", ifc.cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check1("rel_rst_no_rsp", ifc.rsp_valid, 1'b0);
      step();
    end

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      wr     = 1'($urandom_range(1, 0));
      word   = 4'($urandom_range(15, 0));
      addr   = {26'h0, word, 2'b00};
      wdata  = $urandom;
      wait_n = int'($urandom_range(3, 0));
      hold   = int'($urandom_range(2, 0));
      issue(wr, addr, wdata);
      if (wr) begin
        model_write(addr, wdata);
        collect("rand_wr", hold, 32'h0, 1'b0, 3 + wait_n);
      end else begin
        collect("rand_rd", hold, model_read(addr), 1'b0, 4 + wait_n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
